// File: rtl/key_load_ctrl.sv
// Key load controller: accepts a 16-byte key into an external 16x8 shift register and streams it back out.
// Optional macro KEY_ROTATE_EN: stream from the last stage and rotate the stored key by one byte per pass.
module key_load_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Replay,
    input  logic [7:0] Din,
    input  logic       DinValid,
    output logic       DinReady,
    output logic [7:0] SrlD,
    output logic       SrlCE,
    output logic [3:0] SrlAddr,
    input  logic [7:0] SrlQ,
    input  logic [7:0] SrlQ15,
    output logic [7:0] KeyOut,
    output logic       KeyValid,
    output logic       Done,
    output logic       Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

`ifdef KEY_ROTATE_EN
    // Sixteen streamed bytes plus one extra shift that leaves the key rotated.
    localparam logic [4:0] READ_LAST = 5'd16;
`else
    localparam logic [4:0] READ_LAST = 5'd15;
`endif
    localparam logic [4:0] LOAD_LAST = 5'd15;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_next;
    logic       r_loaded;
    logic       w_loaded_next;
    logic [7:0] r_key_out;
    logic       r_key_valid;
    logic       r_done;

    logic       w_accept;
    logic       w_pass;
    logic       w_last_byte;
    logic [7:0] w_tap;
    logic       w_unused;

`ifdef KEY_ROTATE_EN
    assign w_tap    = SrlQ15;
    assign w_unused = ^SrlQ;
`else
    assign w_tap    = SrlQ;
    assign w_unused = ^SrlQ15;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_loaded_next = r_loaded;
        DinReady      = 1'b0;
        SrlCE         = 1'b0;
        SrlD          = 8'h00;
        SrlAddr       = 4'h0;
        w_accept      = 1'b0;
        w_pass        = 1'b0;
        w_last_byte   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = 5'd0;
                if (Start) begin
                    w_state_next = S_LOAD;
                end else if (Replay && r_loaded) begin
                    w_state_next = S_READ;
                end
            end

            S_LOAD: begin
                DinReady = 1'b1;
                w_accept = DinValid;
                if (w_accept) begin
                    SrlCE      = 1'b1;
                    SrlD       = Din;
                    w_cnt_next = r_cnt + 5'd1;
                    if (r_cnt == LOAD_LAST) begin
                        w_loaded_next = 1'b1;
                        w_cnt_next    = 5'd0;
                        w_state_next  = S_READ;
                    end
                end
            end

            S_READ: begin
                w_cnt_next  = r_cnt + 5'd1;
                w_last_byte = (r_cnt == 5'd15);
`ifdef KEY_ROTATE_EN
                // Feed the last stage back to the input so the key recirculates.
                SrlAddr = 4'd15;
                SrlCE   = 1'b1;
                SrlD    = SrlQ15;
                w_pass  = ~r_cnt[4];
`else
                // Oldest byte sits at tap 15; walk the taps down without shifting.
                SrlAddr = 4'd15 - r_cnt[3:0];
                w_pass  = 1'b1;
`endif
                if (r_cnt == READ_LAST) begin
                    w_cnt_next   = 5'd0;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_loaded    <= 1'b0;
            r_key_out   <= 8'h00;
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_loaded    <= w_loaded_next;
            r_key_valid <= w_pass;
            r_done      <= w_last_byte;
            if (w_pass) begin
                r_key_out <= w_tap;
            end
        end
    end

    assign KeyOut   = r_key_out;
    assign KeyValid = r_key_valid;
    assign Done     = r_done;
    assign Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with a behavioural 16x8 shift register attached.
// Expected streams follow KEY_ROTATE_EN when the macro is defined.
module tb_key_load_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start;
    logic       Replay;
    logic [7:0] Din;
    logic       DinValid;
    logic       DinReady;
    logic [7:0] SrlD;
    logic       SrlCE;
    logic [3:0] SrlAddr;
    logic [7:0] SrlQ;
    logic [7:0] SrlQ15;
    logic [7:0] KeyOut;
    logic       KeyValid;
    logic       Done;
    logic       Busy;

    int n_chk = 0;
    int n_fail = 0;
    int rot_n = 0;

    logic [7:0] srl [16];

    key_load_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Replay   (Replay),
        .Din      (Din),
        .DinValid (DinValid),
        .DinReady (DinReady),
        .SrlD     (SrlD),
        .SrlCE    (SrlCE),
        .SrlAddr  (SrlAddr),
        .SrlQ     (SrlQ),
        .SrlQ15   (SrlQ15),
        .KeyOut   (KeyOut),
        .KeyValid (KeyValid),
        .Done     (Done),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    // External shift register: new byte enters stage 0, stage 15 is the oldest.
    always @(posedge CLK) begin
        if (SrlCE === 1'b1) begin
            for (int j = 15; j > 0; j--) srl[j] <= srl[j-1];
            srl[0] <= SrlD;
        end
    end
    assign SrlQ   = srl[SrlAddr];
    assign SrlQ15 = srl[15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [7:0] base, input bit gaps, input bit with_replay);
        Start  = 1'b1;
        Replay = with_replay;
        step();
        Start  = 1'b0;
        Replay = 1'b0;
        check("load_ready", DinReady, 1);
        check("load_busy", Busy, 1);
        for (int k = 0; k < 16; k++) begin
            if (gaps) begin
                DinValid = 1'b0;
                Din      = 8'h5A;
                #2;
                check("gap_ce", SrlCE, 0);
                check("gap_d", SrlD, 0);
                step();
            end
            Din      = base + 8'(k);
            DinValid = 1'b1;
            #2;
            check("acc_ce", SrlCE, 1);
            check("acc_d", SrlD, base + 8'(k));
            step();
        end
        DinValid = 1'b0;
        Din      = 8'h00;
        rot_n    = 0;
        check("read_ready", DinReady, 0);
        check("read_busy", Busy, 1);
    endtask

    task automatic check_stream(input logic [7:0] base, input int poke);
        for (int i = 0; i < 16; i++) begin
            Start = (i == poke);
            #2;
`ifdef KEY_ROTATE_EN
            check("rd_addr", SrlAddr, 15);
            check("rd_ce", SrlCE, 1);
`else
            check("rd_addr", SrlAddr, 15 - i);
            check("rd_ce", SrlCE, 0);
`endif
            step();
            Start = 1'b0;
            check("kv", KeyValid, 1);
            check("key", KeyOut, base + 8'((i + rot_n) % 16));
            check("done", Done, (i == 15));
        end
`ifdef KEY_ROTATE_EN
        check("last_busy", Busy, 1);
        rot_n++;
`else
        check("last_busy", Busy, 0);
`endif
        step();
        check("end_kv", KeyValid, 0);
        check("end_done", Done, 0);
        check("end_busy", Busy, 0);
    endtask

    task automatic replay_go();
        Replay = 1'b1;
        step();
        Replay = 1'b0;
        check("replay_busy", Busy, 1);
    endtask

    task automatic replay_ignored();
        Replay = 1'b1;
        step();
        Replay = 1'b0;
        check("noreplay_busy", Busy, 0);
        check("noreplay_addr", SrlAddr, 0);
        step();
        check("noreplay_busy2", Busy, 0);
        check("noreplay_kv", KeyValid, 0);
    endtask

    initial begin
        RST      = 1'b1;
        Start    = 1'b0;
        Replay   = 1'b0;
        Din      = 8'h00;
        DinValid = 1'b0;
        step();
        step();
        check("rst_busy", Busy, 0);
        check("rst_ready", DinReady, 0);
        check("rst_ce", SrlCE, 0);
        check("rst_kv", KeyValid, 0);
        check("rst_done", Done, 0);
        check("rst_key", KeyOut, 0);
        check("rst_addr", SrlAddr, 0);
        check("rst_d", SrlD, 0);
        RST = 1'b0;
        step();

        // Nothing loaded yet, so Replay must not start a stream.
        replay_ignored();

        do_load(8'h00, 1'b0, 1'b0);
        check_stream(8'h00, -1);
        replay_go();
        check_stream(8'h00, -1);
        replay_go();
        check_stream(8'h00, -1);

        do_load(8'h00, 1'b1, 1'b0);
        check_stream(8'h00, -1);

        // Abort a load after 7 bytes; reset wins over a byte offered that cycle.
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            Din      = 8'h60 + 8'(k);
            DinValid = 1'b1;
            step();
        end
        Din = 8'h77;
        RST = 1'b1;
        step();
        RST      = 1'b0;
        DinValid = 1'b0;
        Din      = 8'h00;
        check("abort_busy", Busy, 0);
        check("abort_ce", SrlCE, 0);
        check("abort_ready", DinReady, 0);
        replay_ignored();

        do_load(8'hA0, 1'b0, 1'b0);
        check_stream(8'hA0, -1);

        // Start with Replay while loaded: Start wins; Start during READ is ignored.
        do_load(8'h30, 1'b0, 1'b1);
        check_stream(8'h30, 4);
        check("post_poke_ready", DinReady, 0);
        replay_go();
        check_stream(8'h30, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_load_ctrl.md
KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 SHALL have a single clock and synchronous, active-high reset: CLK, RST.
REQ-002 Ports SHALL be, in order:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- Start  in  1  begin a 16-byte key load
- Replay  in  1  re-stream the stored key
- Din  in  8  key byte from upstream
- DinValid  in  1  Din valid
- DinReady  out  1  block accepts Din this cycle
- SrlD  out  8  data to 16x8 shift register
- SrlCE  out  1  shift-register shift enable
- SrlAddr  out  4  shift-register tap address
- SrlQ  in  8  shift-register tap data, combinational on SrlAddr
- SrlQ15  in  8  shift-register last stage
- KeyOut  out  8  streamed key byte
- KeyValid  out  1  KeyOut valid
- Done  out  1  pulse with last streamed byte
- Busy  out  1  state not IDLE

Function
REQ-003 FSM SHALL have states IDLE, LOAD, READ.
REQ-004 IDLE: Start=1 -> LOAD; else Replay=1 with Loaded=1 -> READ; Start and Replay together -> Start wins; Replay with Loaded=0 ignored.
REQ-005 Start and Replay SHALL be ignored outside IDLE.
REQ-006 LOAD: DinReady=1; a byte is accepted when DinValid&DinReady; on acceptance SrlCE=1 and SrlD=Din in the same cycle (combinational), else SrlCE=0.
REQ-007 LOAD SHALL count accepted bytes (5-bit counter); on the 16th acceptance set Loaded=1 and go to READ the next cycle; gaps in DinValid stall without penalty.
REQ-008 DinReady SHALL be 0 in IDLE and READ.
REQ-009 READ (no rotate): for pass cycle i=0..15, SrlAddr=15-i, SrlCE=0; first-loaded byte streams first.
REQ-010 KeyOut SHALL register SrlQ with KeyValid=1 one cycle after each pass cycle i=0..15; KeyValid high 16 consecutive cycles, no backpressure.
REQ-011 Done SHALL be 1 in the cycle KeyValid carries byte 15 only; FSM returns to IDLE that same cycle.
REQ-012 Busy SHALL equal (state != IDLE), decoded from the state register.
REQ-013 SrlAddr SHALL be 0 and SrlD 0 whenever not driven by REQ-006/009/019.

Reset
REQ-014 RST SHALL force state IDLE, Loaded=0, counter 0, KeyOut=0, KeyValid=0, Done=0; Busy=0, DinReady=0, SrlCE=0 next cycle.
REQ-015 RST mid-LOAD or mid-READ SHALL abort immediately; partial bytes in the shift register are left uncleared but Loaded=0 blocks Replay until a full reload.
REQ-016 RST SHALL take priority over all inputs in the same cycle.

Configuration
REQ-017 Macro KEY_ROTATE_EN SHALL select the READ mechanism.
REQ-018 Without KEY_ROTATE_EN: READ per REQ-009; shift-register contents unchanged; every Replay streams the identical 16 bytes.
REQ-019 With KEY_ROTATE_EN: READ lasts 17 cycles with SrlAddr=15, SrlCE=1, SrlD=SrlQ15; KeyOut registers SrlQ15 for pass cycles 0..15; cycle 16 is an extra shift with no KeyValid; Done per REQ-011 and IDLE after cycle 16; net effect: stored key rotated left one byte per pass.
REQ-020 Load behaviour, Loaded flag and reset SHALL be identical in both builds.

Verification
REQ-021 Load 0x00..0x0F with DinValid continuous after Start -> 16 SrlCE pulses, READ auto-entered, KeyOut 0x00..0x0F on 16 consecutive KeyValid cycles, Done with 0x0F.
REQ-022 Load with DinValid toggling every other cycle -> exactly 16 accepts, same output stream 0x00..0x0F.
REQ-023 Replay after load, no macro -> 0x00..0x0F again; with KEY_ROTATE_EN -> 0x01..0x0F,0x00, second Replay -> 0x02..0x01.
REQ-024 RST after 7 accepted bytes, then Replay -> ignored (Busy stays 0); then Start + 16 bytes 0xA0..0xAF -> streams 0xA0..0xAF.
REQ-025 Start and Replay asserted together in IDLE with Loaded=1 -> LOAD entered, DinReady=1; Start pulsed during READ -> stream uninterrupted.
